tri_subdivider: RTL

- Sequential, parametrised triangle subdivider for orthogonally projected 3D triangles.
- Accepts one triangle and a subdivision level `d`. Emits 2^d leaf triangles, depth-first, over a valid/ready stream.
- Each split is a newest-vertex bisection of edge p–q.
- Sits between the triangle setup stage and the rasteriser. Replaces the single-level combinational bisection path.

---
 rtl/tri_subdivider.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tri_subdivider.sv
// Depth-first newest-vertex bisection of one triangle into 2^d leaves, one split per cycle.
// Latency: first leaf d+1 cycles after acceptance; each popped subtree at level L yields a leaf L+1 cycles later.
// Backpressure: a leaf holds on tri_out/out_idx/out_last until out_ready; no new triangle is taken until the last leaf leaves.
module tri_subdivider #(
  parameter int COORD_W   = 16,
  parameter int MAX_DEPTH = 3,
  localparam int LVL_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [9*COORD_W-1:0]   tri_in,
  input  logic [LVL_W-1:0]       depth_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9*COORD_W-1:0]   tri_out,
  output logic [MAX_DEPTH-1:0]   out_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam int SP_IW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } vtx_t;

  typedef struct packed {
    vtx_t p;
    vtx_t q;
    vtx_t r;
  } tri_t;

  logic [1:0]       state;
  tri_t             cur;
  tri_t             tri_a;
  tri_t             tri_b;
  vtx_t             mid;
  logic [LVL_W-1:0] lvl;
  logic [LVL_W-1:0] depth_clamp;
  logic [LVL_W-1:0] sp;
  logic [LVL_W-1:0] sp_m1;
  logic [SP_IW-1:0] push_idx;
  logic [SP_IW-1:0] pop_idx;
  logic             stack_empty;
  logic             push;
  logic             pop;

  tri_t             stk_tri [MAX_DEPTH];
  logic [LVL_W-1:0] stk_lvl [MAX_DEPTH];

  // Subtract from the larger value so the sum never leaves COORD_W bits.
  function automatic logic [COORD_W-1:0] half_way(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo + ((hi - lo) >> 1);
  endfunction

  always_comb begin
    mid.x = half_way(cur.p.x, cur.q.x);
    mid.y = half_way(cur.p.y, cur.q.y);
    mid.z = half_way(cur.p.z, cur.q.z);
    tri_a = {cur.p, cur.r, mid};
    tri_b = {cur.r, cur.q, mid};
  end

  assign depth_clamp = (int'(depth_in) > MAX_DEPTH) ? LVL_W'(MAX_DEPTH) : depth_in;
  assign sp_m1       = sp - LVL_W'(1);
  assign push_idx    = SP_IW'(sp);
  assign pop_idx     = SP_IW'(sp_m1);
  assign stack_empty = (sp == '0);
  assign push        = (state == EVAL) && (lvl != '0);
  assign pop         = (state == EMIT) && out_ready && !stack_empty;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && stack_empty;
  assign tri_out   = cur;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cur     <= '0;
      lvl     <= '0;
      sp      <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur     <= tri_in;
            lvl     <= depth_clamp;
            out_idx <= '0;
            state   <= EVAL;
          end
        end
        EVAL: begin
          if (lvl == '0) begin
            state <= EMIT;
          end else begin
            cur <= tri_a;
            lvl <= lvl - LVL_W'(1);
            sp  <= sp + LVL_W'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (pop) begin
              cur     <= stk_tri[pop_idx];
              lvl     <= stk_lvl[pop_idx];
              sp      <= sp_m1;
              out_idx <= out_idx + MAX_DEPTH'(1);
              state   <= EVAL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stack payload needs no reset: sp alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      stk_tri[push_idx] <= tri_b;
      stk_lvl[push_idx] <= lvl - LVL_W'(1);
    end
  end

endmodule
